switch_port_arbiter: RTL and testbench
======================================

Name: switch_port_arbiter

Overview:
Per-output-port round-robin arbiter for the 4-port switch datapath. Each input port requests one output port via valid_in/addr_in. The arbiter grants at most one input per output, holds the grant for the whole packet, and drives the output mux select. A hold watchdog force-releases an output held too long.

Parameters:
NUM_PORTS, 4, number of input ports and of output ports.
ADDR_W, 2, width of destination address; equals clog2(NUM_PORTS).
MAX_HOLD, 16, maximum consecutive grant cycles before forced release; legal range 2..255.

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
valid_in  input  NUM_PORTS  per-input request; high for the duration of a packet
addr_in  input  NUM_PORTS x ADDR_W  per-input destination output port
grant_o  output  NUM_PORTS  per-input grant; the input may transfer data this cycle
out_busy  output  NUM_PORTS  per-output: output currently owned
out_sel  output  NUM_PORTS x ADDR_W  per-output: index of the owning input (mux select)
timeout_o  output  NUM_PORTS  per-output: 1-cycle pulse on forced release

Behaviour:
- Request: input i requests output j when valid_in[i]=1, addr_in[i]=j, and blocked[i]=0.
- Reset (sync, highest priority): grant_o=0, out_busy=0, out_sel=0, timeout_o=0, all RR pointers=0, hold counters=0, blocked=0. Reset mid-packet drops every grant at the next edge.
- Per-output state: IDLE or BUSY(owner). Outputs are fully independent.
- Latency: all outputs are registered. A request sampled at edge n is granted, if won, from edge n (visible in cycle n+1). There is no idle bubble.
- IDLE -> BUSY: among requesters of output j, pick the first index at or after ptr[j], wrapping modulo NUM_PORTS. Set out_sel[j]=winner, out_busy[j]=1, grant_o[winner]=1, hold[j]=1.
- BUSY stays: while the owner still requests j and hold[j] < MAX_HOLD. hold[j] increments by 1 each cycle and saturates at MAX_HOLD.
- Normal release: the owner's request drops (valid_in low, or addr_in changes to another port).
  - Set ptr[j]=owner+1 (wrap).
  - Arbitrate the remaining requesters of j at the same edge using the new pointer.
  - If there are no requesters, go IDLE: out_busy=0, out_sel holds its last value.
- An input whose addr changes mid-packet is treated as a release of the old output. It is a new requester of the new output at the same edge.
- Forced release: owner still requesting and hold[j]==MAX_HOLD.
  - timeout_o[j]=1 for exactly 1 cycle, grant_o[owner]=0.
  - blocked[owner]=1, ptr[j]=owner+1.
  - Other requesters of j are arbitrated at the same edge.
- blocked[i] clears at the edge where valid_in[i]=0 is sampled. While blocked, input i requests nothing.
- grant_o[i] is 1 iff some output is BUSY with owner i. Since each input addresses one output, at most one output per input.
- Simultaneous release on output j and new request from the releasing input to output k: both are handled at the same edge, independently.
- Invariants (asserted in bench):
  - out_busy[j]=0 implies no grant routed via j.
  - No input is owner of two outputs.
  - timeout_o is never high for 2 consecutive cycles on the same output.

Decomposition:
- Package switch_arb_pkg holds:
  - constants NUM_PORTS, ADDR_W, MAX_HOLD defaults;
  - typedef port_idx_t (logic [ADDR_W-1:0]);
  - typedef hold_cnt_t (logic [7:0]);
  - enum out_state_e {OUT_IDLE, OUT_BUSY}.
- One sub-module, rr_out_ctrl: the per-output FSM with RR pointer, hold counter and timeout. It is instantiated NUM_PORTS times.
- The top level does request decode (valid/addr/blocked -> per-output request vectors), blocked flags and the grant OR-reduction.

Test Plan:
- Reset: hold reset 2 cycles with valid_in=4'b1111 -> grant_o=0, out_busy=0, out_sel=0, timeout_o=0 throughout. First grant appears 1 cycle after reset deasserts.
- Contention: inputs 0,1,2 all valid, addr=3, each drops after 3 cycles of its own grant -> output 3 grants 0 (3 cycles), then 1, then 2, with zero bubble cycles. out_sel[3] goes 0,1,2.
- Fairness wrap: ptr[1]=3 after input 2 releases; inputs 0 and 3 request output 1 -> input 3 wins. After it releases, input 0 wins.
- Parallel: input i addr=i for all i, all valid -> all four grants high in the same cycle, out_sel[j]=j.
- Watchdog (MAX_HOLD=4): input 2 holds valid, addr=0, input 1 also requests 0 -> grant_o[2] high 4 cycles, then timeout_o[0] pulses 1 cycle and input 1 is granted. Input 2 is not re-granted until it drops valid for ≥1 cycle.
- Mid-packet events: reset during a BUSY packet -> all grants 0 next cycle. Owner changes addr 1->2 while granted -> output 1 released and re-arbitrated, and output 2 is granted at the same edge if idle.

Source files
------------

// File: rtl/switch_arb_pkg.sv
// Shared constants, types and the round-robin pick helper for the switch port arbiter.
package switch_arb_pkg;

    localparam int NUM_PORTS        = 4;
    localparam int ADDR_W           = 2;
    localparam int DEFAULT_MAX_HOLD = 16;

    typedef logic [ADDR_W-1:0] port_idx_t;
    typedef logic [7:0]        hold_cnt_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_BUSY
    } out_state_e;

    typedef struct packed {
        logic      found;
        port_idx_t idx;
    } rr_pick_t;

    function automatic port_idx_t nextIdx(input port_idx_t idx);
        return port_idx_t'((int'(idx) + 1) % NUM_PORTS);
    endfunction

    // Walks from farthest to nearest so the requester closest to ptr is the last one written.
    function automatic rr_pick_t rrPick(input logic [NUM_PORTS-1:0] req, input port_idx_t ptr);
        rr_pick_t pick;
        int       c;
        pick = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % NUM_PORTS;
            if (req[c]) begin
                pick.found = 1'b1;
                pick.idx   = port_idx_t'(c);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/switch_port_arbiter_rr_out_ctrl.sv
// One output port's owner FSM: round-robin pointer, hold counter and watchdog release.
module rr_out_ctrl
    import switch_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic                 o_busy,
    output port_idx_t            o_sel,
    output logic                 o_timeout,
    output logic                 o_forceRelease
);

    out_state_e           r_state, w_nextState;
    port_idx_t            r_sel, w_nextSel;
    port_idx_t            r_ptr, w_nextPtr;
    port_idx_t            w_arbPtr;
    hold_cnt_t            r_hold, w_nextHold;
    logic                 r_timeout, w_nextTimeout;
    logic [NUM_PORTS-1:0] w_arbReq;
    logic                 w_ownerReq;
    logic                 w_forceRelease;
    logic                 w_release;
    rr_pick_t             w_pick;

    assign w_ownerReq     = i_req[r_sel];
    assign w_forceRelease = (r_state == OUT_BUSY) && w_ownerReq && (r_hold >= hold_cnt_t'(MAX_HOLD));
    assign w_release      = (r_state == OUT_BUSY) && (!w_ownerReq || w_forceRelease);

    // On release the old owner is excluded and the search starts just past it.
    always_comb begin
        w_arbPtr = r_ptr;
        w_arbReq = i_req;
        if (w_release) begin
            w_arbPtr        = nextIdx(r_sel);
            w_arbReq[r_sel] = 1'b0;
        end
    end

    assign w_pick = rrPick(w_arbReq, w_arbPtr);

    always_comb begin
        w_nextState   = r_state;
        w_nextSel     = r_sel;
        w_nextPtr     = r_ptr;
        w_nextHold    = r_hold;
        w_nextTimeout = 1'b0;
        case (r_state)
            OUT_IDLE: begin
                if (w_pick.found) begin
                    w_nextState = OUT_BUSY;
                    w_nextSel   = w_pick.idx;
                    w_nextHold  = 8'd1;
                end
            end
            OUT_BUSY: begin
                if (w_release) begin
                    w_nextPtr     = w_arbPtr;
                    w_nextTimeout = w_forceRelease;
                    if (w_pick.found) begin
                        w_nextSel  = w_pick.idx;
                        w_nextHold = 8'd1;
                    end else begin
                        w_nextState = OUT_IDLE;
                        w_nextHold  = 8'd0;
                    end
                end else if (r_hold < hold_cnt_t'(MAX_HOLD)) begin
                    w_nextHold = r_hold + 8'd1;
                end
            end
            default: w_nextState = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= OUT_IDLE;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_sel     <= w_nextSel;
            r_ptr     <= w_nextPtr;
            r_hold    <= w_nextHold;
            r_timeout <= w_nextTimeout;
        end
    end

    assign o_busy         = (r_state == OUT_BUSY);
    assign o_sel          = r_sel;
    assign o_timeout      = r_timeout;
    assign o_forceRelease = w_forceRelease;

endmodule

// File: rtl/switch_port_arbiter.sv
// Top of the per-output round-robin arbiter: request decode, blocked inputs and grant merge.
module switch_port_arbiter
    import switch_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             valid_in,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_in,
    output logic [NUM_PORTS-1:0]             grant_o,
    output logic [NUM_PORTS-1:0]             out_busy,
    output logic [NUM_PORTS-1:0][ADDR_W-1:0] out_sel,
    output logic [NUM_PORTS-1:0]             timeout_o
);

    logic [NUM_PORTS-1:0] r_blocked;
    logic [NUM_PORTS-1:0] w_blockSet;
    logic [NUM_PORTS-1:0] w_force;
    logic [NUM_PORTS-1:0] w_busy;
    logic [NUM_PORTS-1:0] w_timeout;
    logic [NUM_PORTS-1:0] w_grant;
    logic [NUM_PORTS-1:0] w_reqByOut [NUM_PORTS];
    port_idx_t            w_sel      [NUM_PORTS];

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_reqByOut[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_reqByOut[j][i] = valid_in[i] && (addr_in[i] == port_idx_t'(j)) && !r_blocked[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_out
        rr_out_ctrl #(
            .MAX_HOLD(MAX_HOLD)
        ) u_ctrl (
            .clk           (clk),
            .reset         (reset),
            .i_req         (w_reqByOut[g]),
            .o_busy        (w_busy[g]),
            .o_sel         (w_sel[g]),
            .o_timeout     (w_timeout[g]),
            .o_forceRelease(w_force[g])
        );
        assign out_sel[g] = w_sel[g];
    end

    always_comb begin
        w_grant    = '0;
        w_blockSet = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (w_busy[j]) begin
                w_grant[w_sel[j]] = 1'b1;
            end
            if (w_force[j]) begin
                w_blockSet[w_sel[j]] = 1'b1;
            end
        end
    end

    // A timed-out input stays locked out until it drops valid for at least one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blocked <= '0;
        end else begin
            r_blocked <= (r_blocked | w_blockSet) & valid_in;
        end
    end

    assign grant_o   = w_grant;
    assign out_busy  = w_busy;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Self-checking bench for switch_port_arbiter: directed scenarios plus random traffic vs. an ownership model.
module tb_switch_port_arbiter;

    localparam int NP   = 4;
    localparam int MAXH = 4;

    logic                 clk;
    logic                 reset;
    logic [NP-1:0]        valid_in;
    logic [NP-1:0][1:0]   addr_in;
    logic [NP-1:0]        grant_o;
    logic [NP-1:0]        out_busy;
    logic [NP-1:0][1:0]   out_sel;
    logic [NP-1:0]        timeout_o;

    int checkCount;
    int failCount;

    // Model: owner index per output (-1 when free), next-search pointer, cycles held so far.
    int   mOwner [NP] = '{-1, -1, -1, -1};
    int   mPtr   [NP] = '{0, 0, 0, 0};
    int   mHold  [NP] = '{0, 0, 0, 0};
    int   mSel   [NP] = '{0, 0, 0, 0};
    bit   mTo    [NP] = '{0, 0, 0, 0};
    bit   mBlk   [NP] = '{0, 0, 0, 0};
    logic [NP-1:0] prevTo = '0;

    switch_port_arbiter #(
        .MAX_HOLD(MAXH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .addr_in  (addr_in),
        .grant_o  (grant_o),
        .out_busy (out_busy),
        .out_sel  (out_sel),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs the bench is driving.
    task automatic modelStep(input logic rst);
        bit req    [NP][NP];
        bit newBlk [NP];
        int o;
        int cand;
        if (rst) begin
            for (int j = 0; j < NP; j++) begin
                mOwner[j] = -1;
                mPtr[j]   = 0;
                mHold[j]  = 0;
                mSel[j]   = 0;
                mTo[j]    = 0;
                mBlk[j]   = 0;
            end
            return;
        end
        for (int i = 0; i < NP; i++) begin
            newBlk[i] = 0;
            for (int j = 0; j < NP; j++) begin
                req[i][j] = valid_in[i] && (int'(addr_in[i]) == j) && !mBlk[i];
            end
        end
        for (int j = 0; j < NP; j++) begin
            mTo[j] = 0;
            o = mOwner[j];
            if (o >= 0) begin
                if (req[o][j] && mHold[j] < MAXH) begin
                    mHold[j]++;
                end else begin
                    if (req[o][j]) begin
                        mTo[j]    = 1;
                        newBlk[o] = 1;
                    end
                    mPtr[j]   = (o + 1) % NP;
                    mOwner[j] = -1;
                    mHold[j]  = 0;
                end
            end
            if (mOwner[j] < 0) begin
                for (int k = 0; k < NP; k++) begin
                    cand = (mPtr[j] + k) % NP;
                    if (mOwner[j] < 0 && cand != o && req[cand][j]) begin
                        mOwner[j] = cand;
                        mSel[j]   = cand;
                        mHold[j]  = 1;
                    end
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            mBlk[i] = (mBlk[i] || newBlk[i]) && valid_in[i];
        end
    endtask

    task automatic compareAll();
        logic [NP-1:0]      expGrant;
        logic [NP-1:0]      expBusy;
        logic [NP-1:0][1:0] expSel;
        logic [NP-1:0]      expTo;
        int                 dup;
        expGrant = '0;
        expBusy  = '0;
        expSel   = '0;
        expTo    = '0;
        for (int j = 0; j < NP; j++) begin
            if (mOwner[j] >= 0) begin
                expBusy[j]          = 1'b1;
                expGrant[mOwner[j]] = 1'b1;
            end
            expSel[j] = 2'(mSel[j]);
            expTo[j]  = mTo[j];
        end
        checkOutput("grant", 32'(grant_o), 32'(expGrant));
        checkOutput("busy", 32'(out_busy), 32'(expBusy));
        checkOutput("sel", 32'(out_sel), 32'(expSel));
        checkOutput("timeout", 32'(timeout_o), 32'(expTo));
        checkOutput("timeoutTwice", 32'(timeout_o & prevTo), 32'd0);
        prevTo = timeout_o;
        dup = 0;
        for (int j = 0; j < NP; j++) begin
            for (int k = j + 1; k < NP; k++) begin
                if (out_busy[j] && out_busy[k] && out_sel[j] == out_sel[k]) dup++;
            end
        end
        checkOutput("dualOwner", 32'(dup), 32'd0);
    endtask

    // Drives one cycle of inputs, steps the model at the edge and compares just after it.
    task automatic applyStimulus(input logic rst, input logic [NP-1:0] v, input logic [NP-1:0][1:0] a);
        reset    = rst;
        valid_in = v;
        addr_in  = a;
        @(posedge clk);
        modelStep(rst);
        #1;
        compareAll();
    endtask

    initial begin
        logic [NP-1:0]      rndValid;
        logic [NP-1:0][1:0] rndAddr;
        logic [NP-1:0]      v;
        logic               rst;

        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        valid_in   = '0;
        addr_in    = '0;

        applyStimulus(1'b1, 4'b1111, '0);
        checkOutput("rstGrant", 32'(grant_o), 32'd0);
        applyStimulus(1'b1, 4'b1111, '0);
        checkOutput("rstBusy", 32'(out_busy), 32'd0);
        applyStimulus(1'b0, 4'b1111, '0);
        checkOutput("firstGrant", 32'(grant_o), 32'b0001);
        applyStimulus(1'b0, 4'b0000, '0);

        for (int n = 0; n < 10; n++) begin
            v = (n < 3) ? 4'b0111 : (n < 6) ? 4'b0110 : (n < 9) ? 4'b0100 : 4'b0000;
            applyStimulus(1'b0, v, {4{2'd3}});
            if (n < 9) checkOutput("contNoBubble", 32'(out_busy[3]), 32'd1);
            if (n % 3 == 0 && n < 9) checkOutput("contSel", 32'(out_sel[3]), 32'(n / 3));
        end

        applyStimulus(1'b0, 4'b0100, {2'd0, 2'd1, 2'd0, 2'd0});
        applyStimulus(1'b0, 4'b0000, {2'd0, 2'd1, 2'd0, 2'd0});
        applyStimulus(1'b0, 4'b1001, {2'd1, 2'd0, 2'd0, 2'd1});
        checkOutput("fairWrap", 32'(grant_o), 32'b1000);
        applyStimulus(1'b0, 4'b1001, {2'd1, 2'd0, 2'd0, 2'd1});
        applyStimulus(1'b0, 4'b0001, {2'd1, 2'd0, 2'd0, 2'd1});
        checkOutput("fairNext", 32'(grant_o), 32'b0001);
        applyStimulus(1'b0, 4'b0000, '0);

        applyStimulus(1'b0, 4'b1111, {2'd3, 2'd2, 2'd1, 2'd0});
        checkOutput("parGrant", 32'(grant_o), 32'b1111);
        checkOutput("parSel", 32'(out_sel), 32'he4);
        applyStimulus(1'b0, 4'b0000, '0);

        applyStimulus(1'b0, 4'b0100, '0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 4'b0110, '0);
            checkOutput("wdHold", 32'(grant_o), 32'b0100);
        end
        applyStimulus(1'b0, 4'b0110, '0);
        checkOutput("wdTimeout", 32'(timeout_o), 32'b0001);
        checkOutput("wdHandover", 32'(grant_o), 32'b0010);
        applyStimulus(1'b0, 4'b0110, '0);
        checkOutput("wdPulse", 32'(timeout_o), 32'd0);
        applyStimulus(1'b0, 4'b0100, '0);
        checkOutput("wdBlocked", 32'(grant_o), 32'd0);
        applyStimulus(1'b0, 4'b0000, '0);
        applyStimulus(1'b0, 4'b0100, '0);
        checkOutput("wdRegrant", 32'(grant_o), 32'b0100);
        applyStimulus(1'b0, 4'b0000, '0);

        applyStimulus(1'b0, 4'b0010, {2'd0, 2'd0, 2'd1, 2'd0});
        checkOutput("midGrant", 32'(grant_o), 32'b0010);
        applyStimulus(1'b1, 4'b0010, {2'd0, 2'd0, 2'd1, 2'd0});
        checkOutput("midReset", 32'(grant_o), 32'd0);
        applyStimulus(1'b0, 4'b0010, {2'd0, 2'd0, 2'd1, 2'd0});
        applyStimulus(1'b0, 4'b0011, {2'd0, 2'd0, 2'd2, 2'd1});
        checkOutput("addrMoveGrant", 32'(grant_o), 32'b0011);
        checkOutput("addrMoveBusy", 32'(out_busy), 32'b0110);
        applyStimulus(1'b0, 4'b0000, '0);

        // Sticky random packets so the watchdog and address moves are exercised often.
        rndValid = '0;
        rndAddr  = '0;
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NP; i++) begin
                if (rndValid[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        rndValid[i] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        rndAddr[i] = 2'($urandom_range(0, 3));
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rndValid[i] = 1'b1;
                    rndAddr[i]  = 2'($urandom_range(0, 3));
                end
            end
            applyStimulus(rst, rndValid, rndAddr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
